// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: bus widths, master indices,
// FSM state encodings and the read-return tag.
package ram_arbiter_pkg;

  // Core bus widths reused by the arbiter defaults.
  localparam int CORE_ADDR_W = 32;
  localparam int CORE_DATA_W = 32;

  // Master index constants; also used as the round-robin pointer value.
  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

  // ARB: normal arbitration. LOCK1: M1 owns the RAM while m1_lock stays high.
  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_LOCK1 = 1'b1
  } arb_state_e;

  // Tag for a read issued this cycle, used to route its data next cycle.
  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  // One-hot grant vector for a master index.
  function automatic logic [1:0] onehot_of(input logic idx);
    logic [1:0] vec;
    if (idx == MST_M1) begin
      vec = 2'b10;
    end else begin
      vec = 2'b01;
    end
    return vec;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Master-side bus bundle for the two RAM requesters (M0 core LSU, M1 loader).
interface ram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_lock;

  // Requester view.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata
  );

  // Arbiter view.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata
  );
endinterface

// File: rtl/ram_arbiter_rr_grant2.sv
// Two-requester round-robin grant with per-requester starvation counters.
// When lock_m1 is high only M1 can be granted; M0 keeps counting its wait.
module ram_arbiter_rr_grant2
  import ram_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       lock_m1,
  output logic [1:0] gnt
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic       rr_ptr_r;
  logic [7:0] wait0_r;
  logic [7:0] wait1_r;
  logic       starve0_s;
  logic       starve1_s;
  logic [1:0] gnt_s;

  assign starve0_s = req[0] && (wait0_r == MAX_WAIT_C);
  assign starve1_s = req[1] && (wait1_r == MAX_WAIT_C);

  // Grant selection: lock, then starvation, then sole requester, then pointer.
  always_comb begin
    gnt_s = 2'b00;
    if (lock_m1) begin
      gnt_s = {req[1], 1'b0};
    end else if (starve0_s && starve1_s) begin
      gnt_s = onehot_of(rr_ptr_r);
    end else if (starve0_s) begin
      gnt_s = 2'b01;
    end else if (starve1_s) begin
      gnt_s = 2'b10;
    end else begin
      case (req)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = onehot_of(rr_ptr_r);
        default: gnt_s = 2'b00;
      endcase
    end
  end

  assign gnt = gnt_s;

  // Pointer flips away from each winner; losers that keep requesting count up.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= MST_M0;
      wait0_r  <= 8'd0;
      wait1_r  <= 8'd0;
    end else begin
      if (gnt_s[0]) begin
        rr_ptr_r <= MST_M1;
      end else if (gnt_s[1]) begin
        rr_ptr_r <= MST_M0;
      end

      if (gnt_s[0]) begin
        wait0_r <= 8'd0;
      end else if (req[0] && (wait0_r != MAX_WAIT_C)) begin
        wait0_r <= wait0_r + 8'd1;
      end

      if (gnt_s[1]) begin
        wait1_r <= 8'd0;
      end else if (req[1] && (wait1_r != MAX_WAIT_C)) begin
        wait1_r <= wait1_r + 8'd1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the data RAM's single write and read ports.
// Issues one access per cycle and routes one-cycle-latency read data back
// to the master that issued the read. M1 may lock the RAM for program loads.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = CORE_ADDR_W,
  parameter int DATA_W   = CORE_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      bus,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [DATA_W-1:0] ram_wr_data_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [DATA_W-1:0] ram_rd_data_i
);

  arb_state_e        state_r;
  arb_state_e        state_next_s;
  logic              lock_mode_s;
  logic [1:0]        gnt_raw_s;
  logic [1:0]        gnt_s;
  logic              win_sel_s;
  logic              win_we_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;
  rd_tag_t           rd_tag_r;
  logic              m0_ret_s;
  logic              m1_ret_s;
  logic [DATA_W-1:0] m0_rdata_r;
  logic [DATA_W-1:0] m1_rdata_r;
  logic [DATA_W-1:0] m0_rdata_s;
  logic [DATA_W-1:0] m1_rdata_s;

  // The lock only holds while m1_lock stays high; its release cycle arbitrates normally.
  assign lock_mode_s = (state_r == ST_LOCK1) && bus.m1_lock;

  ram_arbiter_rr_grant2 #(
    .MAX_WAIT (MAX_WAIT)
  ) u_rr_grant2 (
    .clk     (clk),
    .rst     (rst),
    .req     ({bus.m1_req, bus.m0_req}),
    .lock_m1 (lock_mode_s),
    .gnt     (gnt_raw_s)
  );

  // No access is issued while reset is applied.
  always_comb begin
    gnt_s = 2'b00;
    if (rst) begin
      gnt_s = 2'b00;
    end else begin
      gnt_s = gnt_raw_s;
    end
  end

  assign bus.m0_gnt = gnt_s[0];
  assign bus.m1_gnt = gnt_s[1];

  // Lock FSM next state: enter on an M1 grant with lock, leave when lock drops.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_ARB: begin
        if (gnt_s[1] && bus.m1_lock) begin
          state_next_s = ST_LOCK1;
        end else begin
          state_next_s = ST_ARB;
        end
      end
      ST_LOCK1: begin
        if (bus.m1_lock) begin
          state_next_s = ST_LOCK1;
        end else begin
          state_next_s = ST_ARB;
        end
      end
      default: state_next_s = ST_ARB;
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_ARB;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Winner datapath mux; addresses follow M0 when idle, which is harmless.
  always_comb begin
    win_sel_s = gnt_s[1];
    if (win_sel_s == MST_M1) begin
      win_we_s    = bus.m1_we;
      win_addr_s  = bus.m1_addr;
      win_wdata_s = bus.m1_wdata;
    end else begin
      win_we_s    = bus.m0_we;
      win_addr_s  = bus.m0_addr;
      win_wdata_s = bus.m0_wdata;
    end
  end

  assign ram_wr_en_o   = (|gnt_s) && win_we_s;
  assign ram_wr_addr_o = win_addr_s;
  assign ram_wr_data_o = win_wdata_s;
  assign ram_rd_addr_o = win_addr_s;

  // Tag each granted read with its owner so the data can be routed next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_tag_r <= '{valid: 1'b0, owner: MST_M0};
    end else begin
      rd_tag_r.valid <= (|gnt_s) && !win_we_s;
      rd_tag_r.owner <= win_sel_s;
    end
  end

  // A return in progress while reset is applied is discarded.
  assign m0_ret_s = !rst && rd_tag_r.valid && (rd_tag_r.owner == MST_M0);
  assign m1_ret_s = !rst && rd_tag_r.valid && (rd_tag_r.owner == MST_M1);

  // Capture each master's returned word so rdata holds until its next return.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rdata_r <= '0;
      m1_rdata_r <= '0;
    end else begin
      if (m0_ret_s) begin
        m0_rdata_r <= ram_rd_data_i;
      end
      if (m1_ret_s) begin
        m1_rdata_r <= ram_rd_data_i;
      end
    end
  end

  // Present RAM data directly in the return cycle, otherwise the held word.
  always_comb begin
    if (m0_ret_s) begin
      m0_rdata_s = ram_rd_data_i;
    end else begin
      m0_rdata_s = m0_rdata_r;
    end
    if (m1_ret_s) begin
      m1_rdata_s = ram_rd_data_i;
    end else begin
      m1_rdata_s = m1_rdata_r;
    end
  end

  assign bus.m0_rvalid = m0_ret_s;
  assign bus.m1_rvalid = m1_ret_s;
  assign bus.m0_rdata  = m0_rdata_s;
  assign bus.m1_rdata  = m1_rdata_s;

endmodule
